// File: rtl/keyscan_pkg.sv
// Shared types, key map and small helpers for the 4x4 keypad scanner.
package keyscan_pkg;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StHeld,
      StRelease
   } state_e;

   // KEY_MAP[row][col]; row 0 is rows[3], col 0 is cols[3].
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Width needed to hold values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   // True when exactly one of the four active-low lines is asserted.
   function automatic logic one_low(input logic [3:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, ~v[i]};
      end
      return n == 3'd1;
   endfunction

   // Bit position of the lowest asserted (low) line.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; flops clear to zero on reset.
module sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q, sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
   import keyscan_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 1000,
   parameter int unsigned DEB_CYCLES    = 50000,
   parameter int unsigned REPEAT_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DivW = cnt_width(SCAN_DIV);
   localparam int unsigned DebW = cnt_width(DEB_CYCLES);

   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
   localparam logic [DebW-1:0] DebMax  = DebW'(DEB_CYCLES);

   if (SCAN_DIV < 4 || DEB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("keypad_scan: SCAN_DIV, DEB_CYCLES or REPEAT_CYCLES below minimum");
   end

   logic [3:0] srows;

   sync2 #(
      .WIDTH(4)
   ) u_sync (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (rows),
      .q_o   (srows)
   );

   state_e           state_q, state_d;
   logic [3:0]       cols_q, cols_d;
   logic [DivW-1:0]  dwell_q, dwell_d;
   logic [DebW-1:0]  deb_q, deb_d;
   logic [3:0]       cap_q, cap_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;

   logic [DivW-1:0]  dwell_inc;
   logic [DebW-1:0]  deb_inc;
   logic [1:0]       row_idx, col_idx;
   logic [3:0]       cols_next;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RepW = cnt_width(REPEAT_CYCLES);
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
   localparam logic [RepW-1:0] RepMax  = RepW'(REPEAT_CYCLES);

   logic [RepW-1:0] rep_q, rep_d;
   logic [RepW-1:0] rep_inc;

   assign rep_inc = (rep_q == RepMax) ? rep_q : rep_q + 1'b1;
`endif

   // Saturating increments; counters are normally cleared well before the limit.
   assign dwell_inc = (dwell_q == DivMax) ? dwell_q : dwell_q + 1'b1;
   assign deb_inc   = (deb_q == DebMax) ? deb_q : deb_q + 1'b1;
   assign cols_next = {cols_q[2:0], cols_q[3]};
   assign row_idx   = 2'd3 - low_index(cap_q);
   assign col_idx   = 2'd3 - low_index(cols_q);

   // Next-state logic for scan, debounce, hold and release tracking.
   always_comb begin
      state_d     = state_q;
      cols_d      = cols_q;
      dwell_d     = dwell_q;
      deb_d       = deb_q;
      cap_d       = cap_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = rep_q;
`endif
      unique case (state_q)
         StScan: begin
            if (dwell_q == DivLast) begin
               dwell_d = '0;
               if (one_low(srows)) begin
                  cap_d   = srows;
                  deb_d   = '0;
                  state_d = StDebounce;
               end else begin
                  cols_d = cols_next;
               end
            end else begin
               dwell_d = dwell_inc;
            end
         end
         StDebounce: begin
            if (srows == cap_q) begin
               if (deb_q == DebLast) begin
                  key_code_d  = KEY_MAP[row_idx][col_idx];
                  key_valid_d = 1'b1;
                  deb_d       = '0;
                  state_d     = StHeld;
`ifdef KEYPAD_REPEAT_EN
                  rep_d       = '0;
`endif
               end else begin
                  deb_d = deb_inc;
               end
            end else begin
               // Bounce: retry the same column from a fresh dwell.
               deb_d   = '0;
               dwell_d = '0;
               state_d = StScan;
            end
         end
         StHeld: begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == RepLast) begin
               key_valid_d = 1'b1;
               rep_d       = '0;
            end else begin
               rep_d = rep_inc;
            end
`endif
            if (&srows) begin
               deb_d   = '0;
               state_d = StRelease;
            end
         end
         StRelease: begin
            if (!(&srows)) begin
               state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = '0;
`endif
            end else if (deb_q == DebLast) begin
               deb_d   = '0;
               dwell_d = '0;
               cols_d  = cols_next;
               state_d = StScan;
            end else begin
               deb_d = deb_inc;
            end
         end
         default: state_d = StScan;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StScan;
         cols_q      <= 4'b1110;
         dwell_q     <= '0;
         deb_q       <= '0;
         cap_q       <= 4'hF;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cols_q      <= cols_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         cap_q       <= cap_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // Auto-repeat interval counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`endif

   assign cols      = cols_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = (state_q == StHeld) || (state_q == StRelease);

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven before advancing; minimum 4.
REQ-002 Parameter DEB_CYCLES, default 50000: consecutive stable samples required for press and release debounce; minimum 2.
REQ-003 Parameter REPEAT_CYCLES, default 500000: auto-repeat interval; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rows  input  4  keypad row lines; active-low, externally pulled up; asynchronous to clk.
REQ-007 cols  output  4  column drive; active-low, exactly one bit low at all times.
REQ-008 key_code  output  4  hex code of the last accepted key; feeds the downstream digit shift register sin.
REQ-009 key_valid  output  1  one-cycle pulse per accepted key; feeds the downstream shift register en.
REQ-010 key_held  output  1  high while an accepted key is held or its release is being debounced.

Function
REQ-011 rows SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (srows).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 SCAN: cols SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held SCAN_DIV cycles.
REQ-014 SCAN: srows SHALL be evaluated only on the last cycle of each dwell.
REQ-015 SCAN: if exactly one srows bit is low at evaluation, the FSM SHALL capture (row, col), freeze cols and go to DEBOUNCE.
REQ-016 SCAN: if all srows bits are high, or more than one is low, at evaluation, the FSM SHALL advance to the next column.
REQ-017 DEBOUNCE: each cycle with srows equal to the captured pattern SHALL increment the counter.
REQ-018 DEBOUNCE: any mismatch SHALL clear the counter and return to SCAN on the same column with a fresh dwell; no output.
REQ-019 DEBOUNCE: on the cycle after DEB_CYCLES consecutive matches, key_code SHALL take KEY_MAP[row][col], key_valid SHALL pulse for exactly one cycle, and the FSM SHALL enter HELD.
REQ-020 HELD: when srows is all high, the FSM SHALL enter RELEASE with the counter cleared.
REQ-021 RELEASE: any low srows bit SHALL return the FSM to HELD.
REQ-022 RELEASE: DEB_CYCLES consecutive all-high samples SHALL return the FSM to SCAN on the next column.
REQ-023 key_held SHALL be high exactly in HELD and RELEASE.
REQ-024 key_code SHALL hold its value between accepted keys.
REQ-025 Keys in other columns pressed while in DEBOUNCE, HELD or RELEASE SHALL be ignored.
REQ-026 Counters SHALL be $clog2(max(parameter)+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-027 While reset is low: state SCAN, cols=1110, key_code=0, key_valid=0, key_held=0, synchronizer flops and counters cleared.
REQ-028 Reset asserted mid-operation SHALL abort any debounce in progress with no key_valid pulse.
REQ-029 Scanning SHALL restart on the first clk edge after reset deasserts.

Configuration
REQ-030 With KEYPAD_REPEAT_EN defined, each REPEAT_CYCLES consecutive cycles in HELD SHALL re-pulse key_valid with key_code unchanged; the repeat counter clears on entering HELD.
REQ-031 Without KEYPAD_REPEAT_EN, exactly one key_valid pulse SHALL occur per press, and no repeat counter logic SHALL be synthesized.

Structure
REQ-032 Package keyscan_pkg SHALL hold the state enum and KEY_MAP, a 4x4 array of 4-bit codes with rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-033 The synchronizer SHALL be a separate sub-module, sync2, parameterized by width.

Verification (bench uses SCAN_DIV=4, DEB_CYCLES=8, REPEAT_CYCLES=20)
REQ-034 Reset then idle with rows=1111 -> cols cycles 1110, 1101, 1011, 0111 every 4 clks; key_valid never pulses.
REQ-035 Hold rows=1101 while cols=1011 stable -> one key_valid pulse, key_code=8, key_held=1, scanning frozen at 1011.
REQ-036 Bounce rows 1101/1111 alternating every 3 clks during debounce -> no key_valid pulse; then stable -> single pulse.
REQ-037 Release to 1111 for 5 clks, re-press, then release for 8+ clks -> no second pulse; key_held falls; scan resumes at 0111.
REQ-038 Assert reset mid-DEBOUNCE -> cols=1110 and key_code=0 immediately, with no pulse.
REQ-039 rows=1100 (two keys low) -> no accept; with KEYPAD_REPEAT_EN and key 5 held 60 clks after accept -> 3 additional pulses.
